// File: rtl/buffer_config_pkg.sv
// Framebuffer geometry presets and the (x, y) -> linear address mapping
// shared by the writer and the display scanout.
package buffer_config_pkg;

  typedef struct packed {
    int unsigned width;
    int unsigned height;
    int unsigned addr_width;
  } buffer_config_t;

  localparam buffer_config_t BUFFER_160x120x12 = '{width: 160, height: 120, addr_width: 15};

  function automatic logic [31:0] buffer_addr(input buffer_config_t cfg,
                                              input logic [31:0] x,
                                              input logic [31:0] y);
    return y * cfg.width + x;
  endfunction

endpackage

// File: rtl/types_pkg.sv
// Shared pixel/color types for the draw-side pipelines.
package types_pkg;

  typedef logic [11:0] color_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    color_t      color;
  } pixel_write_t;

endpackage

// File: rtl/framebuffer_writer.sv
// Write port of the frame RAM: clipped pixel writes plus a full-buffer clear.
// Optional clipped-pixel counter enabled by FRAMEBUFFER_WRITER_CLIP_COUNT_EN.
module framebuffer_writer
  import types_pkg::*;
  import buffer_config_pkg::*;
#(
  parameter buffer_config_t BUFFER_CONFIG = BUFFER_160x120x12,
  parameter int unsigned COORD_WIDTH = 16,
  localparam int unsigned AW = BUFFER_CONFIG.addr_width
) (
  input  logic                   clk_system,
  input  logic                   rst_system,
  input  logic                   pixel_valid,
  output logic                   pixel_ready,
  input  logic [COORD_WIDTH-1:0] pixel_x,
  input  logic [COORD_WIDTH-1:0] pixel_y,
  input  color_t                 pixel_color,
  input  logic                   clear_start,
  input  color_t                 clear_color,
  output logic                   busy,
  output logic                   clear_done,
  output logic                   write_en,
  output logic [AW-1:0]          write_addr,
  output color_t                 write_data
`ifdef FRAMEBUFFER_WRITER_CLIP_COUNT_EN
  ,
  output logic [15:0]            clip_count
`endif
);

  typedef enum logic {IDLE, CLEAR} writer_state_t;

  localparam logic [31:0] TOTAL = 32'(BUFFER_CONFIG.width * BUFFER_CONFIG.height);

  writer_state_t state, next_state;
  logic [31:0]   clear_cnt;
  color_t        clear_color_q;
  logic [31:0]   x_ext, y_ext, pix_addr;
  logic          in_range, accept;

  assign x_ext    = 32'(pixel_x);
  assign y_ext    = 32'(pixel_y);
  assign pix_addr = buffer_addr(BUFFER_CONFIG, x_ext, y_ext);
  assign in_range = (x_ext < BUFFER_CONFIG.width) && (y_ext < BUFFER_CONFIG.height);

  assign pixel_ready = (state == IDLE) && !clear_start;
  assign accept      = pixel_valid && pixel_ready;
  assign busy        = (state == CLEAR);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (clear_start) next_state = CLEAR;
      CLEAR:   if (clear_cnt == TOTAL) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The first clear write is issued on the same edge that enters CLEAR, so
  // clear_cnt holds the next address to write; reaching TOTAL means all done.
  always_ff @(posedge clk_system or posedge rst_system) begin
    if (rst_system) begin
      state         <= IDLE;
      clear_cnt     <= '0;
      clear_color_q <= '0;
      write_en      <= 1'b0;
      write_addr    <= '0;
      write_data    <= '0;
      clear_done    <= 1'b0;
    end else begin
      state      <= next_state;
      write_en   <= 1'b0;
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_start) begin
            clear_color_q <= clear_color;
            clear_cnt     <= 32'd1;
            write_en      <= 1'b1;
            write_addr    <= '0;
            write_data    <= clear_color;
          end else if (accept && in_range) begin
            write_en   <= 1'b1;
            write_addr <= AW'(pix_addr);
            write_data <= pixel_color;
          end
        end
        CLEAR: begin
          if (clear_cnt == TOTAL) begin
            clear_done <= 1'b1;
            clear_cnt  <= '0;
          end else begin
            write_en   <= 1'b1;
            write_addr <= AW'(clear_cnt);
            write_data <= clear_color_q;
            clear_cnt  <= clear_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FRAMEBUFFER_WRITER_CLIP_COUNT_EN
  always_ff @(posedge clk_system or posedge rst_system) begin
    if (rst_system) begin
      clip_count <= '0;
    end else if ((state == IDLE) && clear_start) begin
      clip_count <= '0;
    end else if (accept && !in_range && (clip_count != 16'hFFFF)) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_framebuffer_writer.sv
// Scoreboard bench for framebuffer_writer (160x120 buffer, 12-bit color).
module tb_framebuffer_writer;
  import types_pkg::*;

  localparam int W     = 160;
  localparam int H     = 120;
  localparam int TOTAL = W * H;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    color_t      data;
  } exp_t;

  logic        clk_system = 1'b0;
  logic        rst_system = 1'b1;
  logic        pixel_valid = 1'b0;
  logic        pixel_ready;
  logic [15:0] pixel_x = '0;
  logic [15:0] pixel_y = '0;
  color_t      pixel_color = '0;
  logic        clear_start = 1'b0;
  color_t      clear_color = '0;
  logic        busy;
  logic        clear_done;
  logic        write_en;
  logic [14:0] write_addr;
  color_t      write_data;
`ifdef FRAMEBUFFER_WRITER_CLIP_COUNT_EN
  logic [15:0] clip_count;
`endif

  framebuffer_writer dut (
    .clk_system (clk_system),
    .rst_system (rst_system),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .pixel_color(pixel_color),
    .clear_start(clear_start),
    .clear_color(clear_color),
    .busy       (busy),
    .clear_done (clear_done),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data)
`ifdef FRAMEBUFFER_WRITER_CLIP_COUNT_EN
    ,
    .clip_count (clip_count)
`endif
  );

  always #5 clk_system = ~clk_system;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   exp_clip = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every RAM write must match the head of the expected queue,
  // including the cycle it was due in.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_system);
      cyc++;
      #1;
      if (write_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write actual addr=%0d data=%h required no write", write_addr, write_data);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(write_addr), e.addr);
          check("write_data", 32'(write_data), 32'(e.data));
          check("write_cycle", cyc, e.cyc);
        end
      end
      if (clear_done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic put_pixel(input int x, input int y, input color_t c);
    int t;
    pixel_valid = 1'b1;
    pixel_x     = 16'(x);
    pixel_y     = 16'(y);
    pixel_color = c;
    for (t = 0; t < 30000; t++) begin
      @(negedge clk_system);
      if (pixel_ready) break;
    end
    check("handshake_timeout", 32'(t >= 30000), 32'd0);
    if (x < W && y < H)
      exp_q.push_back('{cyc: cyc + 1, addr: 32'(y * W + x), data: c});
    else if (exp_clip < 65535)
      exp_clip++;
    @(posedge clk_system);
    #1;
    pixel_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_system);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int t;
    for (t = 0; t < 100 && exp_q.size() != 0; t++) idle_cycles(1);
    idle_cycles(2);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_clear(input color_t c);
    int c0, viol, waited;
    clear_start = 1'b1;
    clear_color = c;
    @(negedge clk_system);
    check("clear_start_idle", 32'(busy), 32'd0);
    check("clear_start_ready", 32'(pixel_ready), 32'd0);
    c0 = cyc;
    for (int k = 0; k < TOTAL; k++)
      exp_q.push_back('{cyc: c0 + 1 + k, addr: 32'(k), data: c});
    exp_clip = 0;
    @(posedge clk_system);
    #1;
    clear_start = 1'b0;
    viol = 0;
    for (waited = 0; waited < TOTAL + 10; waited++) begin
      if (clear_done) break;
      if (!busy || pixel_ready) viol++;
      @(posedge clk_system);
      #1;
    end
    check("clear_busy_ready", 32'(viol), 32'd0);
    check("clear_done_cycle", 32'(cyc), 32'(c0 + 1 + TOTAL));
    check("done_busy", 32'(busy), 32'd0);
    check("done_write_en", 32'(write_en), 32'd0);
    check("done_ready", 32'(pixel_ready), 32'd1);
    idle_cycles(1);
    check("done_pulse", 32'(clear_done), 32'd0);
  endtask

  task automatic check_clip(input string name);
`ifdef FRAMEBUFFER_WRITER_CLIP_COUNT_EN
    check(name, 32'(clip_count), 32'(exp_clip));
`else
    if (name.len() == 0) $display("unnamed clip check");
`endif
  endtask

  initial begin
    int t, d0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_write_en", 32'(write_en), 32'd0);
    check("rst_write_addr", 32'(write_addr), 32'd0);
    check("rst_write_data", 32'(write_data), 32'd0);
    check("rst_clear_done", 32'(clear_done), 32'd0);
    check_clip("rst_clip_count");
    idle_cycles(2);
    rst_system = 1'b0;
    idle_cycles(1);
    check("idle_ready", 32'(pixel_ready), 32'd1);

    put_pixel(3, 2, 12'hF0A);
    drain("single_pixel_drain");

    put_pixel(0, 0, 12'h111);
    put_pixel(1, 0, 12'h222);
    put_pixel(159, 119, 12'h333);
    put_pixel(0, 1, 12'h444);
    drain("burst_drain");

    put_pixel(160, 0, 12'hAAA);
    put_pixel(0, 120, 12'hBBB);
    drain("clip_drain");
    check_clip("clip_count_two");

    do_clear(12'h000);
    check_clip("clip_after_clear");
    drain("clear_drain");

    fork
      do_clear(12'hABC);
      put_pixel(5, 5, 12'h123);
    join
    drain("clear_pixel_drain");

    for (int i = 0; i < 150; i++) begin
      idle_cycles($urandom_range(0, 2));
      put_pixel($urandom_range(0, 175), $urandom_range(0, 130), color_t'($urandom));
    end
    drain("random_drain");
    check_clip("random_clip_count");

    clear_start = 1'b1;
    clear_color = 12'h5A5;
    @(negedge clk_system);
    for (int k = 0; k < TOTAL; k++)
      exp_q.push_back('{cyc: cyc + 1 + k, addr: 32'(k), data: 12'h5A5});
    @(posedge clk_system);
    #1;
    clear_start = 1'b0;
    for (t = 0; t < 300; t++) begin
      if (write_en && write_addr == 15'd100) break;
      idle_cycles(1);
    end
    check("reach_addr_100", 32'(t < 300), 32'd1);
    #1;
    rst_system = 1'b1;
    #1;
    d0 = done_cnt;
    exp_q.delete();
    exp_clip = 0;
    check("arst_write_en", 32'(write_en), 32'd0);
    check("arst_write_addr", 32'(write_addr), 32'd0);
    check("arst_write_data", 32'(write_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(pixel_ready), 32'd1);
    check_clip("arst_clip_count");
    idle_cycles(2);
    rst_system = 1'b0;
    idle_cycles(5);
    check("no_done_after_rst", 32'(done_cnt), 32'(d0));
    put_pixel(7, 3, 12'h777);
    drain("post_reset_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
